i2c_shift_register_param: RTL
=============================

Name: i2c_shift_register_param

Overview:
- Parametrised successor to the team's 8-bit I2C shift register.
- Holds a WIDTH-bit frame that can be parallel-loaded for transmit and serially shifted, one bit per enabled CLOCK edge, in either bit order.
- Counts shifted bits and pulses a frame-done strobe every WIDTH shifts. Presents received data on a parallel output, either live or shadowed.
- Sits between the I2C bus-level controller (which drives the shift enable on SCL timing) and the TMP101 register-access logic.

Parameters:
WIDTH, 8, frame length in bits; legal range 2..32
MSB_FIRST, 1, 1 = shift toward MSB (I2C standard, MSB on ShiftOut first); 0 = LSB first
CW (localparam), $clog2(WIDTH), BitCount width; minimum 1

Ports:
CLOCK  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
WriteLoad  input  1  parallel load of SentData into shift register
SentData  input  WIDTH  transmit frame
ShiftIn  input  1  serial input bit (SDA sample)
ShiftorHold  input  1  1 = shift this cycle; 0 = hold
ShiftOut  output  1  serial output bit (SDA drive value)
ReceivedData  output  WIDTH  parallel received frame
BitCount  output  CW  bits shifted in current frame, 0..WIDTH-1
ByteDone  output  1  one-cycle strobe after WIDTH-th shift

Behaviour:
- Reset asserted (asynchronous): shift register = 0, BitCount = 0, ByteDone = 0, ReceivedData = 0. ShiftOut = 0.
- Reset has effect immediately, even mid-frame. The frame restarts from BitCount = 0 after release.
- Priority per rising CLOCK edge: Reset > WriteLoad > ShiftorHold > hold.
- WriteLoad = 1:
  - sr <= SentData; BitCount <= 0; ByteDone <= 0.
  - ShiftorHold is ignored that cycle; no shift, no count.
- Shift (WriteLoad = 0, ShiftorHold = 1):
  - MSB_FIRST = 1: sr <= {sr[WIDTH-2:0], ShiftIn}.
  - MSB_FIRST = 0: sr <= {ShiftIn, sr[WIDTH-1:1]}.
  - If BitCount == WIDTH-1: BitCount <= 0 (wrap) and ByteDone <= 1. Otherwise BitCount <= BitCount + 1 and ByteDone <= 0.
- Hold (both low): sr and BitCount unchanged; ByteDone <= 0.
- ByteDone is registered:
  - High for exactly one cycle, following the edge that completes the WIDTH-th shift.
  - Continuous shifting produces a strobe every WIDTH cycles with no gap.
- ShiftOut is combinational from the register: sr[WIDTH-1] if MSB_FIRST, else sr[0]. It reflects the bit currently at the output end, so the first transmit bit is valid the cycle after WriteLoad.
- ReceivedData (feature off): equals sr continuously.
- Full duplex: a loaded frame shifts out while a received frame shifts in. After WIDTH shifts, sr holds the received frame in arrival order (first-received bit at MSB when MSB_FIRST = 1, at LSB otherwise).
- WriteLoad mid-frame aborts the frame: BitCount clears and no ByteDone is produced for the partial frame.

Optional Feature:
- Macro: I2C_SR_SHADOW_EN.
- Defined:
  - ReceivedData is a separate WIDTH-bit register, reset 0.
  - It is updated only on the edge completing the WIDTH-th shift, loaded with the post-shift sr value (the same edge that raises ByteDone).
  - It is otherwise stable; WriteLoad does not alter it.
- Undefined: ReceivedData = sr (live, changes every shift); no extra register.

Test Plan:
- Reset mid-frame: WIDTH=8, load 8'hA5, 3 shifts, assert Reset asynchronously between edges -> all outputs 0 immediately. After release, BitCount = 0 and ShiftOut = 0.
- MSB-first transmit/receive: WIDTH=8, MSB_FIRST=1, load 8'hA5, 8 consecutive shifts with ShiftIn sequence 1,0,0,1,0,0,0,0 -> ShiftOut sequence 1,0,1,0,0,1,0,1. ByteDone high one cycle after the 8th shift; ReceivedData = 8'h90; BitCount = 0.
- LSB-first: WIDTH=8, MSB_FIRST=0, load 8'h01, shift with ShiftIn=1 for 8 cycles -> ShiftOut 1 then 0 x7; final ReceivedData = 8'hFF.
- Priority and holds: assert WriteLoad and ShiftorHold together with SentData=8'h3C -> sr = 8'h3C, BitCount = 0, no shift. Interleave 2 hold cycles within 8 shifts -> ByteDone only after the 8th shift edge; BitCount frozen during holds.
- Wrap and back-to-back: WIDTH=12, 24 continuous shifts -> ByteDone pulses exactly twice, 12 cycles apart. BitCount runs 0..11 and wraps. Mid-frame WriteLoad at BitCount=5 -> BitCount = 0, no strobe.
- Shadow (I2C_SR_SHADOW_EN defined): WIDTH=8, shift in 8'hC3 -> ReceivedData stays 0 during shifts 1..7, becomes 8'hC3 on the 8th. It holds through a subsequent WriteLoad and 4 further shifts.

Source files
------------

// File: rtl/i2c_shift_register_param.sv
// rtl/i2c_shift_register_param.sv - parametrised I2C frame shift register (optional macro I2C_SR_SHADOW_EN)
module i2c_shift_register_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic             WriteLoad,
  input  logic [WIDTH-1:0] SentData,
  input  logic             ShiftIn,
  input  logic             ShiftorHold,
  output logic             ShiftOut,
  output logic [WIDTH-1:0] ReceivedData,
  output logic [CW-1:0]    BitCount,
  output logic             ByteDone
);

  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] srShifted;
  logic             shiftNow;
  logic             lastBit;

  // Value the register takes if this cycle shifts, in the configured bit order
  always_comb begin
    srShifted = sr;
    if (MSB_FIRST) begin
      srShifted = {sr[WIDTH-2:0], ShiftIn};
    end else begin
      srShifted = {ShiftIn, sr[WIDTH-1:1]};
    end
  end

  // A load takes precedence, so a shift only happens when WriteLoad is low
  assign shiftNow = ShiftorHold && !WriteLoad;
  assign lastBit  = (BitCount == LastCount);

  // Output end of the register drives SDA
  assign ShiftOut = MSB_FIRST ? sr[WIDTH-1] : sr[0];

  // Frame register, bit counter and frame-done strobe
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      sr       <= '0;
      BitCount <= '0;
      ByteDone <= 1'b0;
    end else if (WriteLoad) begin
      sr       <= SentData;
      BitCount <= '0;
      ByteDone <= 1'b0;
    end else if (ShiftorHold) begin
      sr <= srShifted;
      if (lastBit) begin
        BitCount <= '0;
        ByteDone <= 1'b1;
      end else begin
        BitCount <= BitCount + CW'(1);
        ByteDone <= 1'b0;
      end
    end else begin
      ByteDone <= 1'b0;
    end
  end

`ifdef I2C_SR_SHADOW_EN
  logic [WIDTH-1:0] rxShadow;

  // Capture the completed frame on the same edge that raises ByteDone
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      rxShadow <= '0;
    end else if (shiftNow && lastBit) begin
      rxShadow <= srShifted;
    end
  end

  assign ReceivedData = rxShadow;
`else
  logic unusedShift;
  assign unusedShift  = shiftNow;
  assign ReceivedData = sr;
`endif

endmodule
